sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO. Successor to the team's fixed 8x32 FIFO.
- Generalised data width and depth. Uses the full DEPTH entries via an extra pointer wrap bit.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages in the datapath and in the FIFO verification environment.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 32, number of storage entries; power of two, >=4.
- AF_LEVEL, 28, almost_full asserted when count >= AF_LEVEL (1..DEPTH-1).
- AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL (1..DEPTH-1).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- data_in  in  DATA_W  write data.
- rd  in  1  read request.
- data_out  out  DATA_W  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1, where AW = log2(DEPTH)  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.
- clr_err  in  1  synchronous clear of overflow/underflow.

Behaviour:
- Clock and reset: one clock, clock. Reset rst is asynchronous and active-high; it takes effect immediately, independent of clock.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not cleared.
- Pointers: AW+1 bits. Address = low AW bits.
  - full when the MSBs differ and the low bits are equal.
  - empty when the pointers are equal.
  - Wrap-around from DEPTH-1 to 0 is natural modulo arithmetic; no special case.
- Write accept: wr && (!full || rd_accept). A write to a full FIFO is accepted only when a read is accepted in the same cycle. Accepted data is stored at mem[wr_ptr]; wr_ptr increments at the edge.
- Read accept: rd && !empty. A read to an empty FIFO is rejected even if wr is asserted that cycle; there is no bypass.
- count: +1 on write-only, -1 on read-only, unchanged on both or neither. All flags derive combinationally from the registered count/pointers.
- Standard mode (FWFT=0):
  - data_out <= mem[rd_ptr] on the edge where a read is accepted, so read latency is 1 cycle.
  - data_out holds its value otherwise.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] combinationally whenever !empty. An accepted read pops the head and presents the next word the same cycle after the edge.
  - data_out = 0 while empty.
- Errors:
  - overflow <= 1 on wr && full && !rd_accept.
  - underflow <= 1 on rd && empty.
  - clr_err clears both at the edge. A new error in the same cycle as clr_err wins (flag sets).
  - Rejected operations change no other state.
- Reset mid-operation: all state returns immediately to reset values. Any in-flight accepted operation is lost.
- Parameter checks: elaboration error if DEPTH is not a power of two, or if AF_LEVEL/AE_LEVEL are out of range.

Decomposition:
- Shared package fifo_pkg holds:
  - the clog2-based pointer-width function;
  - the FIFO flag struct typedef (full, empty, almost_full, almost_empty, overflow, underflow);
  - default DATA_W/DEPTH constants.
- One natural sub-module: fifo_mem_dp, a DEPTH x DATA_W array with a synchronous write port and a read port that is async in FWFT mode and registered in standard mode.
- Pointer, count, flag and error logic stay in the top module.

Test Plan:
- Reset then idle (DEPTH=32, AF=28, AE=4) -> empty=1, almost_empty=1, count=0, data_out=0; assert rst mid-stream -> same values immediately, without waiting for a clock edge.
- Write 32 words 0x00..0x1F, then one more write -> full=1 at count=32, almost_full from count=28, overflow=1, pointers unchanged; pulse clr_err -> overflow=0.
- Read 32 words in standard mode -> data_out = 0x00..0x1F, each one cycle after its rd; extra rd -> underflow=1, data_out holds 0x1F.
- Fill to 32, then assert rd&&wr together (data 0xAA) for 40 cycles -> count stays 32, no overflow, pointers wrap; drained order is correct with 0xAA entries last.
- Empty FIFO with rd&&wr together -> write accepted, read rejected, underflow=1, count=1.
- FWFT=1: write 0x5A -> data_out=0x5A in the cycle after the write with no rd; rd pops it -> empty=1, data_out=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// ============================================================================
// fifo_pkg : shared types, defaults and pointer-width helper for sync_fifo_param
// Revision : 1.0
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 32;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_flags_t;

    // Address width for a DEPTH-entry array; pointers carry one extra wrap bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem_dp.sv
// ============================================================================
// fifo_mem_dp : DEPTH x DATA_W storage, sync write, async (FWFT) or registered read
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int FWFT   = 0,
    localparam int AW    = ptr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    input  logic              valid_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is visible as soon as it exists; zero while empty.
            logic unused_fwft;
            assign unused_fwft = rst ^ re_i;
            assign rdata_o     = valid_i ? mem_q[raddr_i] : '0;
        end else begin : g_std
            logic [DATA_W-1:0] rdata_q;
            logic              unused_std;
            assign unused_std = valid_i;

            always_ff @(posedge clock or posedge rst) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (re_i) begin
                    rdata_q <= mem_q[raddr_i];
                end
            end
            assign rdata_o = rdata_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ============================================================================
// sync_fifo_param : parametrised single-clock FIFO with count, programmable
//                   almost flags, sticky error flags and optional FWFT read
// Revision        : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = 28,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0,
    localparam int AW      = ptr_w(DEPTH)
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    generate
        if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("sync_fifo_param: DEPTH must be a power of two >= 4");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH - 1)) begin : g_bad_af
            $error("sync_fifo_param: AF_LEVEL out of range 1..DEPTH-1");
        end
        if ((AE_LEVEL < 1) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
            $error("sync_fifo_param: AE_LEVEL out of range 1..DEPTH-1");
        end
    endgenerate

    localparam logic [AW:0] AF_THR  = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_THR  = AE_LEVEL[AW:0];
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] count_q,  count_d;
    logic        overflow_q,  overflow_d;
    logic        underflow_q, underflow_d;

    fifo_flags_t flags;
    logic        rd_accept;
    logic        wr_accept;

    // Wrap bit distinguishes full from empty when the addresses coincide.
    assign flags.empty        = (wr_ptr_q == rd_ptr_q);
    assign flags.full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign flags.almost_full  = (count_q >= AF_THR);
    assign flags.almost_empty = (count_q <= AE_THR);
    assign flags.overflow     = overflow_q;
    assign flags.underflow    = underflow_q;

    assign rd_accept = rd && !flags.empty;
    assign wr_accept = wr && (!flags.full || rd_accept);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        // A fresh error in the clearing cycle keeps the flag set.
        overflow_d  = (overflow_q && !clr_err) || (wr && flags.full && !rd_accept);
        underflow_d = (underflow_q && !clr_err) || (rd && flags.empty);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT)
    ) u_mem (
        .clock   (clock),
        .rst     (rst),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .re_i    (rd_accept),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .valid_i (!flags.empty),
        .rdata_o (data_out)
    );

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign overflow     = flags.overflow;
    assign underflow    = flags.underflow;
    assign count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ============================================================================
// tb_sync_fifo_param : directed self-checking bench, standard and FWFT instances
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_sync_fifo_param;

    logic       clock = 1'b0;
    logic       rst;
    always #5 clock = ~clock;

    // standard-mode instance
    logic       wr, rd, clr_err;
    logic [7:0] din, dout;
    logic       full, empty, af, ae, ov, un;
    logic [5:0] cnt;

    // FWFT instance
    logic       f_wr, f_rd, f_clr;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [5:0] f_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(0)) u_std (
        .clock(clock), .rst(rst), .wr(wr), .data_in(din), .rd(rd), .clr_err(clr_err),
        .data_out(dout), .full(full), .empty(empty), .almost_full(af),
        .almost_empty(ae), .count(cnt), .overflow(ov), .underflow(un)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(32), .AF_LEVEL(28), .AE_LEVEL(4), .FWFT(1)) u_fw (
        .clock(clock), .rst(rst), .wr(f_wr), .data_in(f_din), .rd(f_rd), .clr_err(f_clr),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .overflow(f_ov), .underflow(f_un)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if ({empty, ae, full, af} !== 4'b1100) begin tests_failed++; $display("FAIL reset_flags: got %b expected 1100", {empty, ae, full, af}); end
        tests_run++; if (cnt !== 6'd0) begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", cnt); end
        tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL reset_dout: got %h expected 00", dout); end
        tests_run++; if ({ov, un} !== 2'b00) begin tests_failed++; $display("FAIL reset_err: got %b expected 00", {ov, un}); end
        @(negedge clock);
        rst = 1'b0;
        wr = 1'b1; din = 8'h11; tick();
        din = 8'h22; tick();
        wr = 1'b0; rd = 1'b1; tick();
        rd = 1'b0;
        tests_run++; if (dout !== 8'h11 || cnt !== 6'd1) begin tests_failed++; $display("FAIL pre_reset_state: got dout=%h cnt=%0d expected 11/1", dout, cnt); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (cnt !== 6'd0 || empty !== 1'b1 || ae !== 1'b1) begin tests_failed++; $display("FAIL async_reset_flags: got cnt=%0d empty=%b ae=%b expected 0/1/1", cnt, empty, ae); end
        tests_run++; if (dout !== 8'h00) begin tests_failed++; $display("FAIL async_reset_dout: got %h expected 00", dout); end
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        wr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din = 8'(i);
            tick();
            tests_run++; if (cnt !== 6'(i + 1)) begin tests_failed++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, cnt, i + 1); end
            tests_run++; if (af !== (i + 1 >= 28) || ae !== (i + 1 <= 4) || full !== (i + 1 == 32)) begin
                tests_failed++; $display("FAIL fill_flags[%0d]: got af=%b ae=%b full=%b", i, af, ae, full);
            end
        end
        din = 8'hEE; tick();
        wr = 1'b0;
        tests_run++; if (ov !== 1'b1 || cnt !== 6'd32 || full !== 1'b1) begin tests_failed++; $display("FAIL overflow_set: got ov=%b cnt=%0d full=%b expected 1/32/1", ov, cnt, full); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        tests_run++; if (ov !== 1'b0 || full !== 1'b1) begin tests_failed++; $display("FAIL overflow_clear: got ov=%b full=%b expected 0/1", ov, full); end
    endtask

    task automatic test_read_std();
        rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            tests_run++; if (dout !== 8'(i) || cnt !== 6'(31 - i)) begin tests_failed++; $display("FAIL read_data[%0d]: got %h cnt=%0d expected %h cnt=%0d", i, dout, cnt, 8'(i), 31 - i); end
        end
        tick();
        rd = 1'b0;
        tests_run++; if (un !== 1'b1 || dout !== 8'h1F || empty !== 1'b1) begin tests_failed++; $display("FAIL underflow_set: got un=%b dout=%h empty=%b expected 1/1f/1", un, dout, empty); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        tests_run++; if (un !== 1'b0) begin tests_failed++; $display("FAIL underflow_clear: got %b expected 0", un); end
    endtask

    task automatic test_back_to_back();
        wr = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din = 8'(8'h40 + i); tick();
        end
        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL b2b_full: got %b expected 1", full); end
        rd = 1'b1; din = 8'hAA;
        for (int k = 0; k < 40; k++) begin
            tick();
            tests_run++; if (cnt !== 6'd32 || ov !== 1'b0) begin tests_failed++; $display("FAIL b2b_count[%0d]: got cnt=%0d ov=%b expected 32/0", k, cnt, ov); end
            tests_run++; if (dout !== ((k < 32) ? 8'(8'h40 + k) : 8'hAA)) begin tests_failed++; $display("FAIL b2b_data[%0d]: got %h", k, dout); end
        end
        wr = 1'b0;
        for (int k = 0; k < 32; k++) begin
            tick();
            tests_run++; if (dout !== 8'hAA) begin tests_failed++; $display("FAIL b2b_drain[%0d]: got %h expected aa", k, dout); end
        end
        rd = 1'b0;
        tests_run++; if (empty !== 1'b1 || un !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got empty=%b un=%b expected 1/0", empty, un); end
    endtask

    task automatic test_empty_rdwr();
        wr = 1'b1; rd = 1'b1; din = 8'h77; tick();
        wr = 1'b0; rd = 1'b0;
        tests_run++; if (cnt !== 6'd1 || un !== 1'b1 || dout !== 8'hAA) begin tests_failed++; $display("FAIL empty_rdwr: got cnt=%0d un=%b dout=%h expected 1/1/aa", cnt, un, dout); end
        clr_err = 1'b1; rd = 1'b1; tick();
        tests_run++; if (un !== 1'b0 || dout !== 8'h77 || empty !== 1'b1) begin tests_failed++; $display("FAIL clr_with_read: got un=%b dout=%h empty=%b expected 0/77/1", un, dout, empty); end
        tick();
        clr_err = 1'b0; rd = 1'b0;
        tests_run++; if (un !== 1'b1) begin tests_failed++; $display("FAIL clr_vs_error: got un=%b expected 1", un); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        tests_run++; if (un !== 1'b0) begin tests_failed++; $display("FAIL clr_final: got un=%b expected 0", un); end
    endtask

    task automatic test_fwft();
        tests_run++; if (f_dout !== 8'h00 || f_empty !== 1'b1) begin tests_failed++; $display("FAIL fwft_idle: got dout=%h empty=%b expected 00/1", f_dout, f_empty); end
        f_wr = 1'b1; f_din = 8'h5A; tick();
        f_wr = 1'b0;
        tests_run++; if (f_dout !== 8'h5A || f_empty !== 1'b0) begin tests_failed++; $display("FAIL fwft_show: got dout=%h empty=%b expected 5a/0", f_dout, f_empty); end
        f_wr = 1'b1; f_din = 8'h3C; tick();
        f_wr = 1'b0;
        tests_run++; if (f_dout !== 8'h5A || f_cnt !== 6'd2) begin tests_failed++; $display("FAIL fwft_head: got dout=%h cnt=%0d expected 5a/2", f_dout, f_cnt); end
        f_rd = 1'b1; tick();
        tests_run++; if (f_dout !== 8'h3C || f_cnt !== 6'd1) begin tests_failed++; $display("FAIL fwft_pop1: got dout=%h cnt=%0d expected 3c/1", f_dout, f_cnt); end
        tick();
        f_rd = 1'b0;
        tests_run++; if (f_dout !== 8'h00 || f_empty !== 1'b1 || f_un !== 1'b0) begin tests_failed++; $display("FAIL fwft_pop2: got dout=%h empty=%b un=%b expected 00/1/0", f_dout, f_empty, f_un); end
    endtask

    initial begin
        rst = 1'b1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0; din = 8'h00;
        f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_din = 8'h00;
        test_reset();
        test_fill();
        test_read_std();
        test_back_to_back();
        test_empty_rdwr();
        test_fwft();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
